// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: UART run-control front end (continuous/step/soft-reset, status frame); DEBUG_CYCLE_COUNT_EN adds the 32-bit cycle counter and 6-byte frame
module debug_run_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  input  logic [PC_W-1:0] pc_in,
  input  logic            halt_in,
  output logic            pipe_enable,
  output logic            pipe_rst,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
);
  typedef enum logic [2:0] {IDLE, RUN, STEP, PRST, SEND} state_t;
  state_t state;
  logic [2:0] idx;
  logic [7:0] rcnt;
  logic first;
  logic [PC_W-1:0] pc_q;
  logic [7:0] pc_b, nxt;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam logic [2:0] LAST = 3'd5;
  logic [31:0] cnt, cnt_q;
`else
  localparam logic [2:0] LAST = 3'd1;
`endif
  // pc comes live on the first SEND cycle, from the snapshot afterwards
  assign pc_b = first ? 8'(pc_in) : 8'(pc_q);
`ifdef DEBUG_CYCLE_COUNT_EN
  // byte to present after frame byte idx is accepted
  always_comb nxt = idx == 3'd0 ? pc_b :
                    idx == 3'd1 ? cnt_q[31:24] :
                    idx == 3'd2 ? cnt_q[23:16] :
                    idx == 3'd3 ? cnt_q[15:8] : cnt_q[7:0];
  // cycle counter counts enabled pipeline cycles; snapshot taken on first SEND cycle
  always_ff @(posedge clk) begin
    if (rst || state == PRST) cnt <= '0;
    else cnt <= cnt + {31'b0, pipe_enable};
    if (rst) cnt_q <= '0;
    else if (state == SEND && first) cnt_q <= cnt;
  end
`else
  assign nxt = pc_b;
`endif
  // command decode, enable/reset sequencing and frame streaming
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pipe_enable <= 1'b0;
      pipe_rst <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
      idx <= 3'd0;
      rcnt <= 8'd0;
      first <= 1'b0;
      pc_q <= '0;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
          if (rx_data == 8'h63 && !halt_in) begin
            state <= RUN;
            pipe_enable <= 1'b1;
          end else if (rx_data == 8'h63 || rx_data == 8'h64) begin
            state <= SEND;
            tx_valid <= 1'b1;
            tx_data <= HEADER;
            idx <= 3'd0;
            first <= 1'b1;
          end else if (rx_data == 8'h73) begin
            state <= STEP;
            pipe_enable <= 1'b1;
          end else if (rx_data == 8'h72) begin
            state <= PRST;
            pipe_rst <= 1'b1;
            rcnt <= 8'(RST_CYCLES - 1);
          end
        end
        RUN: if (halt_in || (rx_valid && rx_data == 8'h70)) begin
          state <= SEND;
          pipe_enable <= 1'b0;
          tx_valid <= 1'b1;
          tx_data <= HEADER;
          idx <= 3'd0;
          first <= 1'b1;
        end
        STEP: begin
          state <= SEND;
          pipe_enable <= 1'b0;
          tx_valid <= 1'b1;
          tx_data <= HEADER;
          idx <= 3'd0;
          first <= 1'b1;
        end
        PRST: if (rcnt == 8'd0) begin
          state <= IDLE;
          pipe_rst <= 1'b0;
        end else rcnt <= rcnt - 8'd1;
        SEND: begin
          first <= 1'b0;
          if (first) pc_q <= pc_in;
          if (tx_ready) begin
            if (idx == LAST) begin
              state <= IDLE;
              tx_valid <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
              tx_data <= nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_run_ctrl.sv
// tb_debug_run_ctrl: queue-based reference model with per-cycle compare plus literal frame checks
module tb_debug_run_ctrl;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, halt_in = 1'b0, tx_ready = 1'b1;
  logic pipe_enable, pipe_rst, tx_valid;
  logic [7:0] rx_data = 8'h00, tx_data;
  logic [6:0] pc_in = 7'h05;
  int checks = 0, failures = 0, en_cnt = 0, prst_cnt = 0;
  logic [7:0] got[$], mq[$];
  bit m_run = 0, m_step = 0, armed = 0, was_idle;
  int m_rl = 0;
  logic [31:0] m_cnt = 0;

  debug_run_ctrl #(.RST_CYCLES(4), .HEADER(8'hA5), .PC_W(7)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .pc_in(pc_in),
    .halt_in(halt_in), .pipe_enable(pipe_enable), .pipe_rst(pipe_rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));

  always #5 clk = ~clk;

  function automatic bit m_idle();
    return !m_run && !m_step && m_rl == 0 && mq.size() == 0;
  endfunction

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endfunction

  // frame the model expects: header, zero-extended pc, then count MSB first
  function automatic void m_send();
    mq = {};
    mq.push_back(8'hA5);
    mq.push_back({1'b0, pc_in});
`ifdef DEBUG_CYCLE_COUNT_EN
    mq.push_back(m_cnt[31:24]);
    mq.push_back(m_cnt[23:16]);
    mq.push_back(m_cnt[15:8]);
    mq.push_back(m_cnt[7:0]);
`endif
  endfunction

  // reference model advanced on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_step = 0; m_rl = 0; mq = {}; m_cnt = 0; armed = 1;
    end else begin
      was_idle = m_idle();
      if (m_run || m_step) m_cnt++;
      if (m_rl > 0) begin m_rl--; m_cnt = 0; end
      if (mq.size() > 0 && tx_ready) void'(mq.pop_front());
      if (m_step) begin
        m_step = 0; m_send();
      end else if (m_run) begin
        if (halt_in || (rx_valid && rx_data == 8'h70)) begin m_run = 0; m_send(); end
      end else if (was_idle && rx_valid) begin
        if (rx_data == 8'h63) begin
          if (halt_in) m_send(); else m_run = 1;
        end else if (rx_data == 8'h73) m_step = 1;
        else if (rx_data == 8'h72) m_rl = 4;
        else if (rx_data == 8'h64) m_send();
      end
    end
  end

  // per-cycle compare away from the active edge
  always @(negedge clk) if (armed) begin
    chk("pipe_enable", pipe_enable, m_run || m_step);
    chk("pipe_rst", pipe_rst, m_rl > 0);
    chk("tx_valid", tx_valid, mq.size() > 0);
    if (mq.size() > 0) chk("tx_data", tx_data, mq[0]);
    if (pipe_enable) en_cnt++;
    if (pipe_rst) prst_cnt++;
    if (tx_valid && tx_ready) got.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic clr();
    got = {};
    en_cnt = 0;
    prst_cnt = 0;
  endtask

  task automatic wait_idle(input string n);
    int i = 0;
    while (i < 200 && !(m_idle() && !tx_valid && !pipe_enable && !pipe_rst)) begin
      tick();
      i++;
    end
    chk({n, "_idle_timeout"}, 32'(i < 200), 32'd1);
    tick();
  endtask

  task automatic chk_frame(input string n, input logic [7:0] pc, input logic [31:0] cnt);
    logic [7:0] e[$];
    bit bad;
    e = {8'hA5, pc};
`ifdef DEBUG_CYCLE_COUNT_EN
    e.push_back(cnt[31:24]);
    e.push_back(cnt[23:16]);
    e.push_back(cnt[15:8]);
    e.push_back(cnt[7:0]);
`endif
    bad = got.size() != e.size();
    for (int i = 0; i < e.size() && !bad; i++) bad = got[i] !== e[i];
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s_frame actual=%0d bytes [%h %h] required pc=%h count=%h", n, got.size(),
               got.size() > 0 ? got[0] : 8'h00, got.size() > 1 ? got[1] : 8'h00, pc, cnt);
    end
  endtask

  initial begin
    int i;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    clr(); send_cmd(8'h73); wait_idle("step");
    chk("step_en_cycles", en_cnt, 1);
    chk_frame("step", 8'h05, 32'h1);
    clr(); send_cmd(8'h72); repeat (8) tick();
    chk("prst_cycles", prst_cnt, 4);
    chk("prst_no_enable", en_cnt, 0);
    clr(); send_cmd(8'h64); wait_idle("dump0");
    chk_frame("dump_after_prst", 8'h05, 32'h0);
    pc_in = 7'h2A;
    clr(); send_cmd(8'h63); repeat (19) tick();
    halt_in = 1'b1; tick(); halt_in = 1'b0;
    wait_idle("run_halt");
    chk("run_en_cycles", en_cnt, 20);
    chk_frame("run_halt", 8'h2A, 32'h14);
    clr(); halt_in = 1'b1; send_cmd(8'h63); halt_in = 1'b0;
    wait_idle("c_halted");
    chk("c_halted_en_cycles", en_cnt, 0);
    chk_frame("c_halted", 8'h2A, 32'h14);
    pc_in = 7'h7F;
    clr(); send_cmd(8'h64);
    i = 0;
    while (i < 60 && !m_idle()) begin
      tx_ready = ~tx_ready;
      rx_valid = (i == 3);
      rx_data = 8'h63;
      tick();
      i++;
    end
    rx_valid = 1'b0; tx_ready = 1'b1;
    wait_idle("toggle");
    chk("toggle_en_cycles", en_cnt, 0);
    chk_frame("toggle", 8'h7F, 32'h14);
    pc_in = 7'h11;
    clr(); send_cmd(8'h63); repeat (3) tick();
    send_cmd(8'h73); send_cmd(8'h41); repeat (2) tick();
    send_cmd(8'h70); wait_idle("run_pause");
    chk("pause_en_cycles", en_cnt, 8);
    chk_frame("run_pause", 8'h11, 32'h1C);
    clr(); send_cmd(8'h64);
    i = 0;
    while (i < 20 && got.size() < 2) begin tick(); i++; end
    chk("abort_reached_byte3", got.size(), 2);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_pipe_enable", pipe_enable, 0);
    chk("abort_pipe_rst", pipe_rst, 0);
    tick();
    clr(); send_cmd(8'h64); wait_idle("after_abort");
    chk_frame("after_abort", 8'h11, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
